addsub_rs: RTL and testbench
============================

Name: addsub_rs

Overview:
- Reservation station for the add/subtract functional unit in the Tomasulo core.
- Accepts instructions from the issue stage and holds their operands or producer tags.
- Snoops the common data bus (CDB) for missing operands and dispatches ready instructions to the add/sub ALU when it reports availability.
- An entry's tag stays live until that entry's result is broadcast on the CDB, so the tag is never reused while a result is in flight.

Parameters:
- ENTRIES, 3: number of station entries (1..7).
- TAG_W, 4: width of producer tags. Tag 0 means "operand valid, no producer".
- BASE_TAG, 1: tag of entry 0. Entry i owns tag BASE_TAG+i. BASE_TAG+ENTRIES-1 must be below 2^TAG_W.
- OP_W, 2: width of the ALU opcode field, using the shared ALU opcode encoding.

Ports:
- clk  in  1  clock.
- nRST  in  1  asynchronous, active-low reset.
- issueEN  in  1  issue request this cycle.
- issueOp  in  OP_W  opcode (add or sub).
- issueQj  in  TAG_W  producer tag of operand 1 (0 = value in issueVj).
- issueVj  in  32  operand 1 value.
- issueQk  in  TAG_W  producer tag of operand 2 (0 = value in issueVk).
- issueVk  in  32  operand 2 value.
- issueFull  out  1  no free entry; issue is refused.
- issueTag  out  TAG_W  tag that will be allocated if issueEN is accepted this cycle (0 when full).
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  broadcasting producer tag.
- cdbData  in  32  broadcast value.
- aluAvailable  in  1  ALU can accept a new operation this cycle.
- dispatchEN  out  1  operation presented to the ALU this cycle.
- dispatchOp  out  OP_W  opcode.
- dispatchData1  out  32  operand 1.
- dispatchData2  out  32  operand 2.
- dispatchTag  out  TAG_W  tag of the dispatched entry, used later for the CDB result.

Behaviour:
- Per-entry state machine: FREE -> WAIT on issue; WAIT -> EXEC on dispatch; EXEC -> FREE when cdbValid && cdbTag == own tag. Per-entry registers: op, Qj, Vj, Qk, Vk.
- Reset (asynchronous):
  - All entries FREE; all Q/V/op registers 0.
  - Outputs settle to issueFull=0, issueTag=BASE_TAG, dispatchEN=0, dispatch data/op/tag all 0.
- Allocation:
  - issueTag is the lowest-index FREE entry, computed combinationally from registered state only.
  - Accepted at posedge when issueEN && !issueFull; the entry becomes WAIT next cycle.
  - issueEN while full is ignored: no state change, no error.
- Issue bypass: if cdbValid and cdbTag == issueQj in the same cycle as the issue (issueQj != 0), store Vj=cdbData and Qj=0. Qk is handled the same way, independently.
- Wakeup: every WAIT entry with Qj == cdbTag (Qj != 0) and cdbValid captures Vj=cdbData and clears Qj at posedge. Same for Qk. Both operands may wake on the same broadcast.
- Ready condition: state==WAIT && Qj==0 && Qk==0, evaluated on registered values. An entry woken at edge N is dispatchable from cycle N+1 at the earliest; there is no CDB-to-dispatch bypass.
- Dispatch:
  - dispatchEN = aluAvailable && any ready entry. It is combinational, and the selected entry is the lowest-index ready one.
  - When dispatchEN=0, the data/op/tag outputs are 0.
  - At posedge with dispatchEN=1, the selected entry moves to EXEC. Its V fields are kept but no longer used.
  - At most one dispatch per cycle.
- Free: EXEC -> FREE on a matching CDB tag. The freed entry is not visible to allocation until the next cycle, because issueFull/issueTag come from registered state.
- Simultaneous events:
  - An issue, one wakeup, one free and one dispatch may all occur in the same cycle on different entries; each is applied independently.
  - A CDB tag matching a WAIT entry's own tag cannot occur legally and is ignored.
  - A CDB tag outside this station's range only performs wakeups.
- Reset mid-operation: all entries return to FREE immediately. In-flight EXEC results are the responsibility of the upstream flush.

Decomposition:
- Shared package / header:
  - entry state encodings sFree, sWait, sExec;
  - ALU opcode constants (ALUAdd, ALUSub);
  - TAG_NONE = 0.
- One natural sub-module, rs_entry: a single entry's state machine, operand capture and CDB compare. It exposes ready, free, tag and the stored fields. Instantiate it ENTRIES times.
- The top level holds the two priority encoders (alloc, dispatch) and the output muxes.

Test Plan:
- Reset, then issue add Qj=0 Vj=5 Qk=0 Vk=7 with aluAvailable=1 -> issueTag=1 during issue; next cycle dispatchEN=1, Data1=5, Data2=7, Tag=1.
- Issue sub with Qj=2, Vk=3 -> no dispatch; cdbValid, cdbTag=2, cdbData=10 -> dispatch the following cycle with Data1=10, Data2=3.
- Issue with Qk=4 in the same cycle as cdbTag=4, cdbData=0x55 -> entry ready next cycle, Data2=0x55.
- Fill 3 entries with Qj=6 -> issueFull=1, issueTag=0, fourth issue ignored. cdbTag=6 -> entry 0 dispatched first, then 1, then 2, each while aluAvailable=1.
- Dispatched tag 1 with cdbTag=1 and simultaneous issueEN -> the new issue does not get tag 1 that cycle; tag 1 is reusable the next cycle.
- Dispatch ready entry with aluAvailable=0 for 3 cycles -> dispatchEN=0 and outputs 0; raise aluAvailable -> dispatch occurs. Assert nRST mid-WAIT -> all entries FREE, issueTag=1.

Source files
------------

// File: rtl/addsub_rs_pkg.sv
// Shared types and constants for the add/sub reservation station.
package addsub_rs_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_NONE = 0;

  localparam logic [1:0] ALUAdd = 2'd0;
  localparam logic [1:0] ALUSub = 2'd1;

  typedef enum logic [1:0] {
    sFree = 2'd0,
    sWait = 2'd1,
    sExec = 2'd2
  } rs_state_e;

endpackage

// File: rtl/addsub_rs_if.sv
// Issue, CDB and dispatch signals between the core and the add/sub reservation station.
interface addsub_rs_if
  import addsub_rs_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 2
) ();

  logic              issueEN;
  logic [OP_W-1:0]   issueOp;
  logic [TAG_W-1:0]  issueQj;
  logic [DATA_W-1:0] issueVj;
  logic [TAG_W-1:0]  issueQk;
  logic [DATA_W-1:0] issueVk;
  logic              issueFull;
  logic [TAG_W-1:0]  issueTag;

  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;

  logic              aluAvailable;
  logic              dispatchEN;
  logic [OP_W-1:0]   dispatchOp;
  logic [DATA_W-1:0] dispatchData1;
  logic [DATA_W-1:0] dispatchData2;
  logic [TAG_W-1:0]  dispatchTag;

  modport slave (
    input  issueEN, issueOp, issueQj, issueVj, issueQk, issueVk,
    input  cdbValid, cdbTag, cdbData, aluAvailable,
    output issueFull, issueTag,
    output dispatchEN, dispatchOp, dispatchData1, dispatchData2, dispatchTag
  );

  modport master (
    output issueEN, issueOp, issueQj, issueVj, issueQk, issueVk,
    output cdbValid, cdbTag, cdbData, aluAvailable,
    input  issueFull, issueTag,
    input  dispatchEN, dispatchOp, dispatchData1, dispatchData2, dispatchTag
  );

endinterface

// File: rtl/addsub_rs_entry.sv
// One reservation-station entry: FREE/WAIT/EXEC lifecycle, operand capture and CDB snooping.
module addsub_rs_entry
  import addsub_rs_pkg::*;
#(
  parameter int unsigned      TAG_W  = 4,
  parameter int unsigned      OP_W   = 2,
  parameter logic [TAG_W-1:0] MY_TAG = '0
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              alloc,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              dispatch_sel,
  output logic              ready,
  output logic              free,
  output logic [TAG_W-1:0]  tag,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  rs_state_e         state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;

  logic issue_hit_j, issue_hit_k, wake_j, wake_k, own_hit;

  // Tag 0 never matches: it marks an operand that already holds its value.
  assign issue_hit_j = cdb_valid && (issue_qj != TAG_W'(TAG_NONE)) && (cdb_tag == issue_qj);
  assign issue_hit_k = cdb_valid && (issue_qk != TAG_W'(TAG_NONE)) && (cdb_tag == issue_qk);
  assign wake_j      = cdb_valid && (qj_q != TAG_W'(TAG_NONE)) && (cdb_tag == qj_q);
  assign wake_k      = cdb_valid && (qk_q != TAG_W'(TAG_NONE)) && (cdb_tag == qk_q);
  assign own_hit     = cdb_valid && (cdb_tag == MY_TAG);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qj_d    = qj_q;
    vj_d    = vj_q;
    qk_d    = qk_q;
    vk_d    = vk_q;
    case (state_q)
      sFree: begin
        if (alloc) begin
          state_d = sWait;
          op_d    = issue_op;
          qj_d    = issue_hit_j ? TAG_W'(TAG_NONE) : issue_qj;
          vj_d    = issue_hit_j ? cdb_data : issue_vj;
          qk_d    = issue_hit_k ? TAG_W'(TAG_NONE) : issue_qk;
          vk_d    = issue_hit_k ? cdb_data : issue_vk;
        end
      end
      sWait: begin
        if (wake_j) begin
          qj_d = TAG_W'(TAG_NONE);
          vj_d = cdb_data;
        end
        if (wake_k) begin
          qk_d = TAG_W'(TAG_NONE);
          vk_d = cdb_data;
        end
        if (dispatch_sel) state_d = sExec;
      end
      sExec: begin
        if (own_hit) state_d = sFree;
      end
      default: state_d = sFree;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= sFree;
      op_q    <= '0;
      qj_q    <= '0;
      vj_q    <= '0;
      qk_q    <= '0;
      vk_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qj_q    <= qj_d;
      vj_q    <= vj_d;
      qk_q    <= qk_d;
      vk_q    <= vk_d;
    end
  end

  assign ready = (state_q == sWait) && (qj_q == TAG_W'(TAG_NONE)) && (qk_q == TAG_W'(TAG_NONE));
  assign free  = (state_q == sFree);
  assign tag   = MY_TAG;
  assign op    = op_q;
  assign vj    = vj_q;
  assign vk    = vk_q;

endmodule

// File: rtl/addsub_rs.sv
// Add/sub reservation station: entry array plus lowest-index allocate and dispatch selection.
module addsub_rs
  import addsub_rs_pkg::*;
#(
  parameter int unsigned ENTRIES  = 3,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned BASE_TAG = 1,
  parameter int unsigned OP_W     = 2
) (
  input  logic        clk,
  input  logic        nRST,
  addsub_rs_if.slave  rs
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] free_vec, ready_vec, alloc_vec, sel_vec;
  logic [TAG_W-1:0]   tag_arr [ENTRIES];
  logic [OP_W-1:0]    op_arr  [ENTRIES];
  logic [DATA_W-1:0]  vj_arr  [ENTRIES];
  logic [DATA_W-1:0]  vk_arr  [ENTRIES];

  logic [IDX_W-1:0] alloc_idx, disp_idx;
  logic             any_free, any_ready, accept, disp_en;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    addsub_rs_entry #(
      .TAG_W  (TAG_W),
      .OP_W   (OP_W),
      .MY_TAG (TAG_W'(BASE_TAG + g))
    ) u_entry (
      .clk          (clk),
      .nRST         (nRST),
      .alloc        (alloc_vec[g]),
      .issue_op     (rs.issueOp),
      .issue_qj     (rs.issueQj),
      .issue_vj     (rs.issueVj),
      .issue_qk     (rs.issueQk),
      .issue_vk     (rs.issueVk),
      .cdb_valid    (rs.cdbValid),
      .cdb_tag      (rs.cdbTag),
      .cdb_data     (rs.cdbData),
      .dispatch_sel (sel_vec[g]),
      .ready        (ready_vec[g]),
      .free         (free_vec[g]),
      .tag          (tag_arr[g]),
      .op           (op_arr[g]),
      .vj           (vj_arr[g]),
      .vk           (vk_arr[g])
    );
  end

  // Lowest-index free and ready entries; both look only at registered entry state.
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    disp_idx  = '0;
    any_ready = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_idx = IDX_W'(i);
        any_free  = 1'b1;
      end
      if (ready_vec[i]) begin
        disp_idx  = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign accept  = rs.issueEN && any_free;
  assign disp_en = rs.aluAvailable && any_ready;

  always_comb begin
    alloc_vec = '0;
    sel_vec   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_vec[i] = accept  && (alloc_idx == IDX_W'(i));
      sel_vec[i]   = disp_en && (disp_idx == IDX_W'(i));
    end
  end

  assign rs.issueFull     = !any_free;
  assign rs.issueTag      = any_free ? (TAG_W'(BASE_TAG) + TAG_W'(alloc_idx)) : '0;
  assign rs.dispatchEN    = disp_en;
  assign rs.dispatchOp    = disp_en ? op_arr[disp_idx]  : '0;
  assign rs.dispatchData1 = disp_en ? vj_arr[disp_idx]  : '0;
  assign rs.dispatchData2 = disp_en ? vk_arr[disp_idx]  : '0;
  assign rs.dispatchTag   = disp_en ? tag_arr[disp_idx] : '0;

endmodule

// File: tb/tb_addsub_rs.sv
// Bench for addsub_rs: directed scenarios plus random traffic against a per-entry reference model.
module tb_addsub_rs;
  import addsub_rs_pkg::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  addsub_rs_if #(.TAG_W(4), .OP_W(2)) ifc ();

  addsub_rs #(.ENTRIES(N), .TAG_W(4), .BASE_TAG(1), .OP_W(2)) dut (
    .clk  (clk),
    .nRST (nRST),
    .rs   (ifc)
  );

  // Reference model: 0 = free, 1 = waiting, 2 = executing.
  int          m_st [N];
  logic [1:0]  m_op [N];
  logic [3:0]  m_qj [N];
  logic [3:0]  m_qk [N];
  logic [31:0] m_vj [N];
  logic [31:0] m_vk [N];

  logic        obs_full, obs_den;
  logic [3:0]  obs_tag, obs_dtag;
  logic [1:0]  obs_op;
  logic [31:0] obs_d1, obs_d2;

  int n_chk = 0;
  int n_pass = 0;

  logic        r_en, r_cv, r_alu;
  logic [1:0]  r_op;
  logic [3:0]  r_qj, r_qk, r_ct;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic sample();
    obs_full = ifc.issueFull;
    obs_tag  = ifc.issueTag;
    obs_den  = ifc.dispatchEN;
    obs_op   = ifc.dispatchOp;
    obs_d1   = ifc.dispatchData1;
    obs_d2   = ifc.dispatchData2;
    obs_dtag = ifc.dispatchTag;
  endtask

  task automatic step(input logic en, input logic [1:0] op,
                      input logic [3:0] qj, input logic [31:0] vj,
                      input logic [3:0] qk, input logic [31:0] vk,
                      input logic cv, input logic [3:0] ct, input logic [31:0] cd,
                      input logic alu);
    int a, d;
    logic e_den;
    @(negedge clk);
    ifc.issueEN = en; ifc.issueOp = op;
    ifc.issueQj = qj; ifc.issueVj = vj; ifc.issueQk = qk; ifc.issueVk = vk;
    ifc.cdbValid = cv; ifc.cdbTag = ct; ifc.cdbData = cd;
    ifc.aluAvailable = alu;
    #2;
    a = -1;
    d = -1;
    for (int i = 0; i < N; i++) begin
      if (a < 0 && m_st[i] == 0) a = i;
      if (d < 0 && m_st[i] == 1 && m_qj[i] == 0 && m_qk[i] == 0) d = i;
    end
    e_den = alu && (d >= 0);
    sample();
    chk("issueFull", 32'(obs_full), 32'(a < 0));
    chk("issueTag",  32'(obs_tag),  (a < 0) ? 32'd0 : 32'(a + 1));
    chk("dispEN",    32'(obs_den),  32'(e_den));
    chk("dispOp",    32'(obs_op),   e_den ? 32'(m_op[d]) : 32'd0);
    chk("dispD1",    obs_d1,        e_den ? m_vj[d] : 32'd0);
    chk("dispD2",    obs_d2,        e_den ? m_vk[d] : 32'd0);
    chk("dispTag",   32'(obs_dtag), e_den ? 32'(d + 1) : 32'd0);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1) begin
        if (cv && ct != 0 && m_qj[i] == ct) begin m_qj[i] = 0; m_vj[i] = cd; end
        if (cv && ct != 0 && m_qk[i] == ct) begin m_qk[i] = 0; m_vk[i] = cd; end
        if (e_den && i == d) m_st[i] = 2;
      end else if (m_st[i] == 2) begin
        if (cv && ct == 4'(i + 1)) m_st[i] = 0;
      end else if (en && i == a) begin
        m_st[i] = 1;
        m_op[i] = op;
        m_qj[i] = (cv && qj != 0 && ct == qj) ? 4'd0 : qj;
        m_vj[i] = (cv && qj != 0 && ct == qj) ? cd : vj;
        m_qk[i] = (cv && qk != 0 && ct == qk) ? 4'd0 : qk;
        m_vk[i] = (cv && qk != 0 && ct == qk) ? cd : vk;
      end
    end
  endtask

  task automatic idle(input logic alu);
    step(1'b0, 2'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, alu);
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] v, input logic alu);
    step(1'b0, 2'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, t, v, alu);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    ifc.issueEN = 1'b0; ifc.cdbValid = 1'b0; ifc.aluAvailable = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_op[i] = '0; m_qj[i] = '0; m_qk[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
    end
    #2;
    sample();
    chk("rst_full", 32'(obs_full), 32'd0);
    chk("rst_tag",  32'(obs_tag),  32'd1);
    chk("rst_den",  32'(obs_den),  32'd0);
    chk("rst_d1",   obs_d1,        32'd0);
    chk("rst_dtag", 32'(obs_dtag), 32'd0);
    @(posedge clk);
    #2 nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    ifc.issueEN = 1'b0; ifc.issueOp = '0; ifc.issueQj = '0; ifc.issueVj = '0;
    ifc.issueQk = '0; ifc.issueVk = '0; ifc.cdbValid = 1'b0; ifc.cdbTag = '0;
    ifc.cdbData = '0; ifc.aluAvailable = 1'b0;
    do_reset();

    // Both operands ready at issue: dispatch the next cycle
    step(1'b1, ALUAdd, 4'd0, 32'd5, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 1'b1);
    chk("t1_itag", 32'(obs_tag), 32'd1);
    chk("t1_nodisp", 32'(obs_den), 32'd0);
    idle(1'b1);
    chk("t1_den", 32'(obs_den), 32'd1);
    chk("t1_d1", obs_d1, 32'd5);
    chk("t1_d2", obs_d2, 32'd7);
    chk("t1_dtag", 32'(obs_dtag), 32'd1);
    bcast(4'd1, 32'h1234, 1'b1);

    // Operand 1 arrives later via the CDB
    step(1'b1, ALUSub, 4'd2, 32'd0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1);
    idle(1'b1);
    chk("t2_wait", 32'(obs_den), 32'd0);
    bcast(4'd2, 32'd10, 1'b1);
    chk("t2_nobypass", 32'(obs_den), 32'd0);
    idle(1'b1);
    chk("t2_den", 32'(obs_den), 32'd1);
    chk("t2_d1", obs_d1, 32'd10);
    chk("t2_d2", obs_d2, 32'd3);
    chk("t2_op", 32'(obs_op), 32'(ALUSub));
    bcast(4'd1, 32'h0, 1'b0);

    // Issue-cycle bypass on operand 2
    step(1'b1, ALUAdd, 4'd0, 32'd1, 4'd4, 32'd0, 1'b1, 4'd4, 32'h55, 1'b1);
    idle(1'b1);
    chk("t3_den", 32'(obs_den), 32'd1);
    chk("t3_d2", obs_d2, 32'h55);
    bcast(4'd1, 32'h0, 1'b0);

    // Fill the station, refuse a fourth issue, then drain in index order
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ALUAdd, 4'd6, 32'd0, 4'd0, 32'(k), 1'b0, 4'd0, 32'd0, 1'b1);
      chk("t4_itag", 32'(obs_tag), 32'(k + 1));
    end
    step(1'b1, ALUSub, 4'd0, 32'd9, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 1'b1);
    chk("t4_full", 32'(obs_full), 32'd1);
    chk("t4_tag0", 32'(obs_tag), 32'd0);
    bcast(4'd6, 32'h66, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("t4_dtag", 32'(obs_dtag), 32'(k + 1));
      chk("t4_d1", obs_d1, 32'h66);
      chk("t4_d2", obs_d2, 32'(k));
    end
    for (int k = 1; k <= 3; k++) bcast(4'(k), 32'h0, 1'b0);

    // A tag freed this cycle is not handed out until the next
    step(1'b1, ALUAdd, 4'd0, 32'd8, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 1'b1);
    idle(1'b1);
    step(1'b1, ALUAdd, 4'd0, 32'd1, 4'd0, 32'd2, 1'b1, 4'd1, 32'h77, 1'b0);
    chk("t5_notag1", 32'(obs_tag), 32'd2);
    idle(1'b0);
    chk("t5_tag1", 32'(obs_tag), 32'd1);
    do_reset();

    // ALU back-pressure, then reset with an entry still waiting
    step(1'b1, ALUSub, 4'd0, 32'd20, 4'd0, 32'd4, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      chk("t6_hold", 32'(obs_den), 32'd0);
      chk("t6_zero", obs_d1, 32'd0);
    end
    idle(1'b1);
    chk("t6_den", 32'(obs_den), 32'd1);
    chk("t6_d1", obs_d1, 32'd20);
    step(1'b1, ALUAdd, 4'd9, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    do_reset();

    // Random traffic; CDB never names a waiting entry's own tag
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      r_en  = 1'($urandom_range(0, 1));
      r_op  = ($urandom_range(0, 1) == 0) ? ALUAdd : ALUSub;
      r_qj  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(4, 9));
      r_qk  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(4, 9));
      r_cv  = ($urandom_range(0, 9) < 6);
      r_ct  = 4'($urandom_range(0, 9));
      if (r_ct >= 4'd1 && r_ct <= 4'd3 && m_st[int'(r_ct) - 1] == 1) r_cv = 1'b0;
      r_alu = ($urandom_range(0, 3) != 0);
      step(r_en, r_op, r_qj, $urandom, r_qk, $urandom, r_cv, r_ct, $urandom, r_alu);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
